// File: rtl/psum_writeback_accumulator.sv
// -----------------------------------------------------------------------------
// psum_writeback_accumulator
//
// Write side of the im2col convolution datapath. The PE array produces one psum
// per ofmap pixel per input channel, in ofmap raster order, one full channel
// at a time. This block accumulates those psums across input channels by
// read-modify-write into the ofmap SRAM:
//   - channel 0     : ofmap = sat(psum + bias)          (no SRAM read)
//   - channel k > 0 : ofmap = sat(psum + ofmap_old)     (SRAM read, 1-cycle data)
//   - last channel  : optional ReLU applied to the value written
//
// Pipeline:
//   stage 1 (accept cycle t) : issue the SRAM read, register psum and tags
//   stage 2 (cycle t+1)      : add, saturate, ReLU, write back
//
// When ofmap_len == 1, consecutive accepts hit the same address. The read in
// cycle t+1 then races the write of the previous result, so that result is
// forwarded from stage 2 instead of using the stale SRAM data.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   start_i                  one-cycle pulse, latches config and starts a layer
//   ofmap_len_i              ofmap pixels per channel
//   channel_num_i            number of input channels to accumulate
//   bias_i                   signed bias, added on channel 0
//   relu_en_i                apply ReLU on final-channel writes
//   psum_valid_i/psum_data_i psum stream from the PE array
//   psum_ready_o             block accepts a psum this cycle
//   rd_en_o/rd_addr_o        SRAM read port (address driven combinationally)
//   rd_data_i                SRAM read data, valid one cycle after rd_en_o
//   wr_en_o/wr_addr_o/wr_data_o  SRAM write port
//   busy_o                   layer in progress
//   done_o                   one-cycle pulse when the layer is fully written
// -----------------------------------------------------------------------------
module psum_writeback_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CH_WIDTH   = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [ADDR_WIDTH-1:0]        ofmap_len_i,
  input  logic [CH_WIDTH-1:0]          channel_num_i,
  input  logic signed [DATA_WIDTH-1:0] bias_i,
  input  logic                         relu_en_i,
  input  logic                         psum_valid_i,
  input  logic signed [DATA_WIDTH-1:0] psum_data_i,
  output logic                         psum_ready_o,
  output logic                         rd_en_o,
  output logic [ADDR_WIDTH-1:0]        rd_addr_o,
  input  logic signed [DATA_WIDTH-1:0] rd_data_i,
  output logic                         wr_en_o,
  output logic [ADDR_WIDTH-1:0]        wr_addr_o,
  output logic signed [DATA_WIDTH-1:0] wr_data_o,
  output logic                         busy_o,
  output logic                         done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CH_WIDTH-1:0]   CH_ONE   = CH_WIDTH'(1);

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                         state_q,   state_d;

  // Layer configuration, latched on start
  logic [ADDR_WIDTH-1:0]          len_q,     len_d;
  logic [CH_WIDTH-1:0]            chn_q,     chn_d;
  logic signed [DATA_WIDTH-1:0]   bias_q,    bias_d;
  logic                           relu_q,    relu_d;

  // Position of the next psum to be accepted
  logic [ADDR_WIDTH-1:0]          pix_cnt_q, pix_cnt_d;
  logic [CH_WIDTH-1:0]            ch_cnt_q,  ch_cnt_d;

  // Stage-1 pipeline register (the accepted psum and its tags)
  logic                           s1_valid_q, s1_valid_d;
  logic signed [DATA_WIDTH-1:0]   s1_psum_q,  s1_psum_d;
  logic [ADDR_WIDTH-1:0]          s1_addr_q,  s1_addr_d;
  logic                           s1_first_q, s1_first_d;
  logic                           s1_last_q,  s1_last_d;
  logic                           s1_fwd_q,   s1_fwd_d;
  logic signed [DATA_WIDTH-1:0]   fwd_data_q, fwd_data_d;

  // ---------------------------------------------------------------------------
  // Handshake and position decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic pix_last;
  logic ch_first;
  logic ch_last;

  assign psum_ready_o = (state_q == S_RUN);
  assign accept       = psum_ready_o & psum_valid_i;
  assign pix_last     = (pix_cnt_q == (len_q - ADDR_ONE));
  assign ch_first     = (ch_cnt_q == '0);
  assign ch_last      = (ch_cnt_q == (chn_q - CH_ONE));

  assign busy_o = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done_o = (state_q == S_DONE);

  // Channel 0 starts from the bias, so only later channels read the SRAM.
  assign rd_en_o   = accept & ~ch_first;
  assign rd_addr_o = pix_cnt_q;

  // ---------------------------------------------------------------------------
  // FSM and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    len_d     = len_q;
    chn_d     = chn_q;
    bias_d    = bias_q;
    relu_d    = relu_q;
    pix_cnt_d = pix_cnt_q;
    ch_cnt_d  = ch_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d     = ofmap_len_i;
          chn_d     = channel_num_i;
          bias_d    = bias_i;
          relu_d    = relu_en_i;
          pix_cnt_d = '0;
          ch_cnt_d  = '0;
          // An empty layer has nothing to write; report completion at once.
          if ((ofmap_len_i == '0) || (channel_num_i == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (accept) begin
          if (pix_last) begin
            pix_cnt_d = '0;
            if (ch_last) begin
              ch_cnt_d = '0;
              state_d  = S_FLUSH;
            end else begin
              ch_cnt_d = ch_cnt_q + CH_ONE;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + ADDR_ONE;
          end
        end
      end

      // The final accepted psum is written by stage 2 during this cycle.
      S_FLUSH: state_d = S_DONE;

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2: operand select, saturating add, ReLU
  // ---------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] operand;
  logic signed [DATA_WIDTH:0]   sum_wide;
  logic signed [DATA_WIDTH-1:0] sum_sat;
  logic signed [DATA_WIDTH-1:0] sum_out;

  always_comb begin
    operand = rd_data_i;
    if (s1_first_q) begin
      operand = bias_q;
    end else if (s1_fwd_q) begin
      operand = fwd_data_q;
    end

    // One guard bit: the two top bits differ exactly when the add overflowed.
    sum_wide = {s1_psum_q[DATA_WIDTH-1], s1_psum_q} + {operand[DATA_WIDTH-1], operand};

    if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
      sum_sat = sum_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_sat = sum_wide[DATA_WIDTH-1:0];
    end

    sum_out = sum_sat;
    if (s1_last_q && relu_q && sum_sat[DATA_WIDTH-1]) begin
      sum_out = '0;
    end
  end

  assign wr_en_o   = s1_valid_q;
  assign wr_addr_o = s1_addr_q;
  // Held at zero between writes so the port is quiet outside write cycles.
  assign wr_data_o = s1_valid_q ? sum_out : '0;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the accepted psum and detect the read-after-write race
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = accept;
    s1_psum_d  = s1_psum_q;
    s1_addr_d  = s1_addr_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    if (accept) begin
      s1_psum_d  = psum_data_i;
      s1_addr_d  = pix_cnt_q;
      s1_first_d = ch_first;
      s1_last_d  = ch_last;
    end

    // The SRAM returns the pre-write value when a read and a write to the same
    // address share a cycle, so the value being written is kept for the next
    // stage 2. A re-read address is never on the last channel, so the
    // pre-ReLU sum equals the value actually written.
    s1_fwd_d   = accept & ~ch_first & s1_valid_q & (s1_addr_q == pix_cnt_q);
    fwd_data_d = sum_sat;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the control so that all
  // outputs are defined and quiet directly after reset; there is no storage
  // array here whose reset would be costly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      chn_q      <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      pix_cnt_q  <= '0;
      ch_cnt_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_psum_q  <= '0;
      s1_addr_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_fwd_q   <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      len_q      <= len_d;
      chn_q      <= chn_d;
      bias_q     <= bias_d;
      relu_q     <= relu_d;
      pix_cnt_q  <= pix_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_psum_q  <= s1_psum_d;
      s1_addr_q  <= s1_addr_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_fwd_q   <= s1_fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_psum_writeback_accumulator.sv
// -----------------------------------------------------------------------------
// Testbench for psum_writeback_accumulator.
//
// An SRAM model (read data one cycle after rd_en, read-before-write on a
// same-address collision) is attached to the read/write ports. A reference
// model maps the k-th accepted psum to (channel, pixel) = (k / len, k % len)
// and accumulates per pixel with integer arithmetic, clamping, and ReLU; each
// accept queues the expected write, due exactly one cycle later.
// -----------------------------------------------------------------------------
module tb_psum_writeback_accumulator;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int CW = 6;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        ofmap_len;
  logic [CW-1:0]        channel_num;
  logic signed [DW-1:0] bias;
  logic                 relu_en;
  logic                 psum_valid;
  logic signed [DW-1:0] psum_data;
  logic                 psum_ready;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 busy;
  logic                 done;

  psum_writeback_accumulator #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CH_WIDTH   (CW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .ofmap_len_i   (ofmap_len),
    .channel_num_i (channel_num),
    .bias_i        (bias),
    .relu_en_i     (relu_en),
    .psum_valid_i  (psum_valid),
    .psum_data_i   (psum_data),
    .psum_ready_o  (psum_ready),
    .rd_en_o       (rd_en),
    .rd_addr_o     (rd_addr),
    .rd_data_i     (rd_data),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered read, write takes effect at the same edge, so a
  // same-cycle read of the written address returns the old contents.
  logic signed [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int due;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  m_len, m_chn, m_bias;
  bit  m_relu;
  int  acc_cnt, wr_cnt, done_cnt, last_acc_cyc;
  int  img [1024];

  function automatic int clamp(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(negedge clk) begin
    int  p, c, v;
    wr_t w;
    if (rst_n) begin
      if (psum_valid && psum_ready) begin
        p = acc_cnt % m_len;
        c = acc_cnt / m_len;
        check("rd_en_on_accept", int'(rd_en), int'(c != 0));
        if (c != 0) check("rd_addr", int'(rd_addr), p);
        v = clamp(((c == 0) ? m_bias : img[p]) + int'(psum_data));
        if (c == m_chn - 1 && m_relu && v < 0) v = 0;
        img[p] = v;
        exp_q.push_back('{cyc + 1, p, v});
        acc_cnt++;
        last_acc_cyc = cyc;
      end else begin
        check("rd_en_idle", int'(rd_en), 0);
      end

      if (wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("wr_cycle", cyc, w.due);
          check("wr_addr", int'(wr_addr), w.addr);
          check("wr_data", int'(wr_data), w.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("wr_missing", 0, 1);
        void'(exp_q.pop_front());
      end

      if (done) begin
        done_cnt++;
        if (acc_cnt > 0) check("done_latency", cyc, last_acc_cyc + 2);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int stim[$];

  task automatic push(input int v);
    stim.push_back(v);
  endtask

  // Runs one layer over the psums in stim. bubble_pct sets the random bubble
  // rate; alt forces a bubble every other cycle; mid_start pulses start on the
  // first bubble; abort_at > 0 asserts reset after that many accepts.
  task automatic run_layer(input int len, input int chn, input int bias_v,
                           input bit relu, input int bubble_pct, input bit alt,
                           input bit mid_start, input int abort_at);
    int i     = 0;
    int guard = 0;
    bit rdy;
    bit mid_done = 1'b0;
    bit phase    = 1'b0;
    bit bubble;

    m_len = len; m_chn = chn; m_bias = bias_v; m_relu = relu;
    acc_cnt = 0; wr_cnt = 0; done_cnt = 0;
    exp_q.delete();

    @(posedge clk); #1;
    start       = 1'b1;
    ofmap_len   = AW'(len);
    channel_num = CW'(chn);
    bias        = DW'(bias_v);
    relu_en     = relu;
    @(posedge clk); #1;
    start       = 1'b0;
    // Scramble config inputs: the block must use the latched values.
    ofmap_len   = AW'($urandom);
    channel_num = CW'($urandom);
    bias        = DW'($urandom);
    relu_en     = 1'($urandom);
    check("busy_after_start", int'(busy), int'(len != 0 && chn != 0));

    while (i < stim.size() && guard < 2000) begin
      guard++;
      bubble = alt ? phase : ($urandom_range(99) < bubble_pct);
      phase  = ~phase;
      if (bubble) begin
        psum_valid = 1'b0;
        psum_data  = DW'($urandom);
        if (mid_start && !mid_done) begin
          start       = 1'b1;
          ofmap_len   = AW'(len + 3);
          channel_num = CW'(chn + 1);
          mid_done    = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        psum_valid = 1'b1;
        psum_data  = DW'(stim[i]);
        @(negedge clk);
        rdy = psum_ready;
        @(posedge clk); #1;
        if (rdy) begin
          i++;
          if (i == abort_at) begin
            // The write of the psum just accepted and the read of the next
            // one are both live in this cycle when reset hits.
            psum_valid = 1'b1;
            psum_data  = DW'(stim[i]);
            #1;
            rst_n = 1'b0;
            #1;
            check("rst_wr_en", int'(wr_en), 0);
            check("rst_rd_en", int'(rd_en), 0);
            check("rst_psum_ready", int'(psum_ready), 0);
            check("rst_busy", int'(busy), 0);
            psum_valid = 1'b0;
            repeat (3) @(posedge clk);
            check("rst_no_done", int'(done), 0);
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(posedge clk);
            check("rst_done_cnt", done_cnt, 0);
            return;
          end
        end
      end
    end
    psum_valid = 1'b0;
    if (i < stim.size()) check("psum_timeout", i, stim.size());

    if (stim.size() > 0) begin
      @(negedge clk);
      check("ready_drop", int'(psum_ready), 0);
    end

    guard = 0;
    while (done_cnt == 0 && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("busy_end", int'(busy), 0);
    check("wr_total", wr_cnt, len * chn);
    check("exp_drained", exp_q.size(), 0);
  endtask

  task automatic load_scn1();
    stim.delete(); push(1); push(2); push(-5); push(7);
  endtask

  task automatic check_scn1_image();
    check("s1_mem0", int'(mem[0]), 4);
    check("s1_mem1", int'(mem[1]), 5);
    check("s1_mem2", int'(mem[2]), -2);
    check("s1_mem3", int'(mem[3]), 10);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DW-1:0] r16;
    int len, chn, b;

    rst_n = 1'b0; start = 1'b0; ofmap_len = '0; channel_num = '0; bias = '0;
    relu_en = 1'b0; psum_valid = 1'b0; psum_data = '0;
    m_len = 1; m_chn = 1; m_bias = 0; m_relu = 1'b0;
    acc_cnt = 0; wr_cnt = 0; done_cnt = 0; last_acc_cyc = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_psum_ready", int'(psum_ready), 0);
    check("reset_rd_en", int'(rd_en), 0);
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_wr_data", int'(wr_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;

    // Single channel with bias
    load_scn1();
    run_layer(4, 1, 3, 1'b0, 0, 1'b0, 1'b0, -1);
    check_scn1_image();

    // Two channels, ReLU on the last
    stim.delete(); push(5); push(-1); push(2); push(-10); push(0); push(3);
    run_layer(3, 2, 0, 1'b1, 0, 1'b0, 1'b0, -1);
    check("s2_mem0", int'(mem[0]), 0);
    check("s2_mem1", int'(mem[1]), 0);
    check("s2_mem2", int'(mem[2]), 5);

    // Positive and negative saturation
    stim.delete(); push(30000); push(5); push(10000); push(6);
    run_layer(2, 2, 0, 1'b0, 0, 1'b0, 1'b0, -1);
    check("s3_pos_sat", int'(mem[0]), 32767);
    check("s3_pix1", int'(mem[1]), 11);
    stim.delete(); push(-30000); push(0); push(-10000); push(0);
    run_layer(2, 2, 0, 1'b0, 0, 1'b0, 1'b0, -1);
    check("s3_neg_sat", int'(mem[0]), -32768);

    // Single pixel: every accept after the first needs forwarding
    stim.delete(); push(2); push(3); push(4);
    run_layer(1, 3, 1, 1'b0, 0, 1'b0, 1'b0, -1);
    check("s4_mem0", int'(mem[0]), 10);

    // Bubbles every other cycle plus an ignored start
    for (int k = 0; k < 4; k++) mem[k] = '0;
    load_scn1();
    run_layer(4, 1, 3, 1'b0, 0, 1'b1, 1'b1, -1);
    check_scn1_image();

    // Reset mid-layer, then a clean layer
    stim.delete(); push(5); push(-1); push(2); push(-10); push(0); push(3);
    run_layer(3, 2, 0, 1'b1, 0, 1'b0, 1'b0, 4);
    for (int k = 0; k < 4; k++) mem[k] = '0;
    load_scn1();
    run_layer(4, 1, 3, 1'b0, 0, 1'b0, 1'b0, -1);
    check_scn1_image();

    // Degenerate configurations: done with no writes
    stim.delete();
    run_layer(4, 0, 3, 1'b0, 0, 1'b0, 1'b0, -1);
    run_layer(0, 2, 3, 1'b0, 0, 1'b0, 1'b0, -1);

    // Random layers
    for (int n = 0; n < 30; n++) begin
      len = $urandom_range(5, 1);
      chn = $urandom_range(4, 1);
      r16 = DW'($urandom);
      b   = (n % 3 == 0) ? int'(r16) : int'($urandom_range(200)) - 100;
      stim.delete();
      for (int k = 0; k < len * chn; k++) begin
        r16 = DW'($urandom);
        push((n % 2 == 0) ? int'(r16) : int'($urandom_range(400)) - 200);
      end
      run_layer(len, chn, b, 1'($urandom), $urandom_range(40), 1'b0, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_writeback_accumulator.md
Name: psum_writeback_accumulator

Overview:
- Write-side counterpart of the im2col read-address generator.
- Consumes the per-pixel psum stream from the PE array, in im2col row order. This is ofmap raster order, one psum per ofmap pixel per input channel.
- Accumulates psums across input channels by read-modify-write into ofmap SRAM, with bias on the first channel and optional ReLU on the last.
- Sits between the PE psum output and the ofmap SRAM ports.

Parameters:
- DATA_WIDTH, 16, signed psum/ofmap word width.
- ADDR_WIDTH, 10, ofmap SRAM address width.
- CH_WIDTH, 6, width of channel count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse; latches config and begins a layer.
- ofmap_len  in  ADDR_WIDTH  number of ofmap pixels per channel (e.g. 576).
- channel_num  in  CH_WIDTH  number of input channels to accumulate.
- bias  in  DATA_WIDTH  signed bias, added on channel 0.
- relu_en  in  1  apply ReLU on final-channel writes.
- psum_valid  in  1  psum_data valid.
- psum_data  in  DATA_WIDTH  signed psum.
- psum_ready  out  1  block accepts psum this cycle.
- rd_en  out  1  SRAM read strobe.
- rd_addr  out  ADDR_WIDTH  SRAM read address.
- rd_data  in  DATA_WIDTH  SRAM read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  SRAM write strobe.
- wr_addr  out  ADDR_WIDTH  SRAM write address.
- wr_data  out  DATA_WIDTH  SRAM write data.
- busy  out  1  layer in progress.
- done  out  1  one-cycle pulse when the layer is fully written.

Behaviour:
- **Reset:** all outputs 0, FSM IDLE, counters 0, pipeline invalid.
- **FSM states:** IDLE, RUN, FLUSH, DONE.
  - IDLE: start latches ofmap_len, channel_num, bias, relu_en.
  - IDLE: if ofmap_len==0 or channel_num==0, go to DONE; otherwise go to RUN.
  - IDLE: busy=1 from the cycle after start until done.
  - start while not IDLE is ignored.
- **RUN:** psum_ready=1; accept when psum_valid & psum_ready.
  - pix_cnt (0..ofmap_len-1) increments per accept.
  - On wrap, pix_cnt clears and ch_cnt increments.
  - Accept of the last psum (ch_cnt==channel_num-1, pix_cnt==ofmap_len-1) goes to FLUSH, with psum_ready=0 from the next cycle.
- **FLUSH:** wait one cycle for stage 2 to write, then go to DONE.
- **DONE:** done=1 for exactly one cycle, busy=0, then return to IDLE.
- **Stage 1 (accept cycle t):**
  - Register psum, addr=pix_cnt, first=(ch_cnt==0), last=(ch_cnt==channel_num-1).
  - If not first: rd_en=1, rd_addr=pix_cnt combinationally in cycle t.
  - Channel-0 accepts issue no read.
- **Stage 2 (cycle t+1):**
  - operand = bias if first; else forwarded data if hazard; else rd_data.
  - sum = saturate(psum + operand) to signed DATA_WIDTH: clamp to +32767 / -32768 at the default width.
  - If last & relu_en & sum<0, sum=0.
  - wr_en=1, wr_addr=addr, wr_data=sum.
  - Write latency is therefore 1 cycle after accept for all channels.
- **Hazard:** when stage 2 writes address A in cycle t+1 and stage 1 reads A in the same cycle, the read returns stale data.
  - The block compares addresses and substitutes the stage-2 wr_data (pre-ReLU is never needed because only non-last writes are re-read) on the following cycle.
  - This is possible only for ofmap_len==1.
- **Bubbles:** psum_valid low in RUN produces no read, no write and no counter change; the pipeline drains normally.
- **Widths:** counters ADDR_WIDTH/CH_WIDTH unsigned; arithmetic in DATA_WIDTH+1 bits before saturation.
- **Reset mid-operation:** immediate return to IDLE, all strobes low in the same cycle reset asserts, no done pulse; a partial SRAM image is acceptable.

Test Plan:
1. **Single channel:** ofmap_len=4, channel_num=1, bias=3, relu_en=0, psums 1,2,-5,7 back-to-back.
   - Writes (0,4),(1,5),(2,-2),(3,10), each 1 cycle after accept.
   - rd_en never high; done 2 cycles after last accept; busy then 0.
2. **Two channels with ReLU:** ofmap_len=3, channel_num=2, bias=0, relu_en=1, psums ch0 {5,-1,2}, ch1 {-10,0,3}.
   - ch0 writes 5,-1,2; ch1 reads each address 1 cycle ahead of its write.
   - ch1 writes 0,0,5 (ReLU clamps -5 and -1).
3. **Saturation:** channel_num=2, ofmap_len=2, ch0 psum=30000, ch1 psum=10000 at pixel 0, bias=0.
   - Final wr_data=32767; a negative case with -30000 + -10000 gives -32768.
4. **Forwarding:** ofmap_len=1, channel_num=3, bias=1, psums 2,3,4 back-to-back, relu_en=0.
   - Writes 3, 6, 10 at addr 0; no stale rd_data used.
5. **Bubbles and ignored start:** scenario 1 with psum_valid low every other cycle, plus a start pulse mid-layer.
   - Identical write data/addresses, writes only after accepts, start ignored, single done.
6. **Reset and degenerate config:**
   - reset driven low mid-RUN of scenario 2: wr_en/rd_en/psum_ready low immediately, no done; a new start afterwards completes scenario 1 correctly.
   - start with channel_num=0: done pulses with zero writes.
